decode_uop_queue: RTL and testbench

Elastic uop buffer between the decode_top outputs and the rename stage. It accepts decode bundles of 1–2 uop tags and stores them per uop in a circular buffer. It presents up to two uops per cycle to rename under a valid/ready handshake, which decouples decode from rename back-pressure. It also supports a pipeline flush and flags illegal uop counts.

---
 rtl/decode_uop_queue.sv | 142 ++++++++++++++
 tb/tb_decode_uop_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/decode_uop_queue.sv
// Elastic uop buffer between decode and rename: stores 1-2 uops per bundle in a
// circular buffer and presents up to two uops per cycle to rename.
package decode_uop_queue_pkg;
   typedef enum logic [3:0] {
      UOP_INT_ALU       = 4'd0,
      UOP_INT_MUL       = 4'd1,
      UOP_LD_U8         = 4'd2,
      UOP_ST_U8         = 4'd3,
      UOP_BRANCH        = 4'd4,
      UOP_CAP_JUMP      = 4'd5,
      UOP_LINK          = 4'd6,
      UOP_PREFIX_SELECT = 4'd7
   } uop_tag_t;
endpackage

module decode_uop_queue
   import decode_uop_queue_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int MAX_UOPS = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         dec_valid_i,
   input  uop_tag_t                     dec_uop0_i,
   input  uop_tag_t                     dec_uop1_i,
   input  logic [1:0]                   dec_uop_count_i,
   output logic                         dec_ready_o,
   output logic                         ren_valid_o,
   output uop_tag_t                     ren_uop0_o,
   output uop_tag_t                     ren_uop1_o,
   output logic [1:0]                   ren_uop_count_o,
   input  logic                         ren_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
   output logic                         illegal_count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH + 1);

   uop_tag_t         mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [OW-1:0]    occ_r;
   logic             illegal_r;

   logic             push_s;
   logic             pop_s;
   logic [1:0]       push_n_s;
   logic [1:0]       push_eff_s;
   logic [1:0]       pop_n_s;
   logic             we0_s;
   logic             we1_s;
   logic             illegal_set_s;
   logic [PW-1:0]    wr_ptr1_s;
   logic [PW-1:0]    wr_ptr_next_s;
   logic [PW-1:0]    rd_ptr_next_s;
   logic [PW-1:0]    rd_ptr1_next_s;
   logic [OW-1:0]    occ_next_s;
   uop_tag_t         rd0_next_s;
   uop_tag_t         rd1_next_s;

   assign occupancy_o     = occ_r;
   assign illegal_count_o = illegal_r;

   // Handshake decode and next-state pointer/occupancy arithmetic
   always_comb begin
      push_s        = dec_valid_i && dec_ready_o;
      push_n_s      = (dec_uop_count_i > 2'(MAX_UOPS)) ? 2'(MAX_UOPS) : dec_uop_count_i;
      push_eff_s    = push_s ? push_n_s : 2'd0;
      pop_s         = ren_valid_o && ren_ready_i;
      pop_n_s       = pop_s ? ren_uop_count_o : 2'd0;
      we0_s         = push_s && !flush_i && (push_n_s != 2'd0);
      we1_s         = push_s && !flush_i && (push_n_s == 2'd2);
      illegal_set_s = push_s && !flush_i && (dec_uop_count_i == 2'd3);
      wr_ptr1_s     = wr_ptr_r + PW'(1);
      if (flush_i) begin
         occ_next_s    = '0;
         wr_ptr_next_s = '0;
         rd_ptr_next_s = '0;
      end else begin
         occ_next_s    = occ_r + OW'(push_eff_s) - OW'(pop_n_s);
         wr_ptr_next_s = wr_ptr_r + PW'(push_eff_s);
         rd_ptr_next_s = rd_ptr_r + PW'(pop_n_s);
      end
   end

   // Next-cycle head entries, forwarding this cycle's writes so outputs can be registered
   always_comb begin
      rd_ptr1_next_s = rd_ptr_next_s + PW'(1);
      if (we0_s && (rd_ptr_next_s == wr_ptr_r)) begin
         rd0_next_s = dec_uop0_i;
      end else if (we1_s && (rd_ptr_next_s == wr_ptr1_s)) begin
         rd0_next_s = dec_uop1_i;
      end else begin
         rd0_next_s = mem_r[rd_ptr_next_s];
      end
      if (we0_s && (rd_ptr1_next_s == wr_ptr_r)) begin
         rd1_next_s = dec_uop0_i;
      end else if (we1_s && (rd_ptr1_next_s == wr_ptr1_s)) begin
         rd1_next_s = dec_uop1_i;
      end else begin
         rd1_next_s = mem_r[rd_ptr1_next_s];
      end
   end

   // Uop storage; unreset because every read is masked by occupancy
   always_ff @(posedge clk_i) begin
      if (we0_s) begin
         mem_r[wr_ptr_r] <= dec_uop0_i;
      end
      if (we1_s) begin
         mem_r[wr_ptr1_s] <= dec_uop1_i;
      end
   end

   // Queue state and registered rename/decode-side outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         occ_r           <= '0;
         wr_ptr_r        <= '0;
         rd_ptr_r        <= '0;
         illegal_r       <= 1'b0;
         dec_ready_o     <= 1'b1;
         ren_valid_o     <= 1'b0;
         ren_uop_count_o <= 2'd0;
         ren_uop0_o      <= UOP_INT_ALU;
         ren_uop1_o      <= UOP_INT_ALU;
      end else begin
         occ_r           <= occ_next_s;
         wr_ptr_r        <= wr_ptr_next_s;
         rd_ptr_r        <= rd_ptr_next_s;
         illegal_r       <= illegal_r | illegal_set_s;
         dec_ready_o     <= (occ_next_s <= OW'(DEPTH - 2));
         ren_valid_o     <= (occ_next_s != OW'(0));
         ren_uop_count_o <= (occ_next_s >= OW'(2)) ? 2'd2 : occ_next_s[1:0];
         ren_uop0_o      <= (occ_next_s >= OW'(1)) ? rd0_next_s : UOP_INT_ALU;
         ren_uop1_o      <= (occ_next_s >= OW'(2)) ? rd1_next_s : UOP_INT_ALU;
      end
   end

endmodule

// File: tb/tb_decode_uop_queue.sv
// Randomized and directed bench for decode_uop_queue against a queue-based model.
module tb_decode_uop_queue;
   import decode_uop_queue_pkg::*;

   localparam int DEPTH = 8;
   localparam int OW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst, flush, dec_valid, dec_ready, ren_valid, ren_ready, illegal;
   uop_tag_t      u0, u1, r0, r1;
   logic [1:0]    dcnt, rcnt;
   logic [OW-1:0] occ;

   int        total = 0;
   int        bad = 0;
   bit        chk_en = 1'b0;
   bit        stream_on = 1'b0;
   int        stream_pushed = 0;
   uop_tag_t  mq[$];
   bit        m_ill = 1'b0;
   uop_tag_t  pool [8];

   always #5 clk = ~clk;

   decode_uop_queue #(.DEPTH(DEPTH), .MAX_UOPS(2)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .dec_valid_i(dec_valid), .dec_uop0_i(u0), .dec_uop1_i(u1),
      .dec_uop_count_i(dcnt), .dec_ready_o(dec_ready),
      .ren_valid_o(ren_valid), .ren_uop0_o(r0), .ren_uop1_o(r1),
      .ren_uop_count_o(rcnt), .ren_ready_i(ren_ready),
      .occupancy_o(occ), .illegal_count_o(illegal)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a program-order queue of uops
   always @(posedge clk) begin
      int sz, popn, pushn;
      bit rdy;
      sz  = mq.size();
      rdy = (DEPTH - sz) >= 2;
      if (rst) begin
         mq.delete();
         m_ill = 1'b0;
      end else if (flush) begin
         mq.delete();
      end else begin
         popn  = (ren_ready && sz > 0) ? ((sz >= 2) ? 2 : sz) : 0;
         pushn = 0;
         if (dec_valid && rdy) begin
            pushn = (dcnt == 2'd3) ? 2 : int'(dcnt);
            if (dcnt == 2'd3) m_ill = 1'b1;
         end
         repeat (popn) void'(mq.pop_front());
         if (pushn >= 1) mq.push_back(u0);
         if (pushn == 2) mq.push_back(u1);
         if (stream_on) stream_pushed += pushn;
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      int sz;
      if (chk_en) begin
         sz = mq.size();
         chk("dec_ready", dec_ready, (DEPTH - sz) >= 2);
         chk("ren_valid", ren_valid, sz != 0);
         chk("ren_count", rcnt, (sz >= 2) ? 2 : sz);
         chk("ren_uop0", r0, (sz >= 1) ? mq[0] : UOP_INT_ALU);
         chk("ren_uop1", r1, (sz >= 2) ? mq[1] : UOP_INT_ALU);
         chk("occupancy", occ, sz);
         chk("illegal", illegal, m_ill);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      dec_valid = 1'b0; ren_ready = 1'b0; flush = 1'b0; dcnt = 2'd0;
   endtask

   initial begin
      pool = '{UOP_INT_ALU, UOP_INT_MUL, UOP_LD_U8, UOP_ST_U8,
               UOP_BRANCH, UOP_CAP_JUMP, UOP_LINK, UOP_PREFIX_SELECT};
      rst = 1'b1; flush = 1'b0; ren_ready = 1'b0;
      dec_valid = 1'b1; dcnt = 2'd2; u0 = UOP_LINK; u1 = UOP_BRANCH;

      // Reset with valid held high
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0; idle();
      chk("rst_valid", ren_valid, 1'b0);
      chk("rst_ready", dec_ready, 1'b1);
      chk("rst_occ", occ, 0);
      chk("rst_uop0", r0, UOP_INT_ALU);

      // Single push, visible one cycle later
      dec_valid = 1'b1; dcnt = 2'd1; u0 = UOP_PREFIX_SELECT;
      chk("push_cycle_valid", ren_valid, 1'b0);
      tick();
      idle();
      chk("single_valid", ren_valid, 1'b1);
      chk("single_count", rcnt, 2'd1);
      chk("single_uop0", r0, UOP_PREFIX_SELECT);
      chk("single_occ", occ, 1);
      ren_ready = 1'b1; tick(); idle();

      // Repacking across bundle boundaries
      dec_valid = 1'b1; dcnt = 2'd2; u0 = UOP_CAP_JUMP; u1 = UOP_LINK; tick();
      dcnt = 2'd1; u0 = UOP_ST_U8; tick();
      idle();
      chk("repack_occ", occ, 3);
      chk("repack_uop0", r0, UOP_CAP_JUMP);
      chk("repack_uop1", r1, UOP_LINK);
      chk("repack_count", rcnt, 2'd2);
      ren_ready = 1'b1; tick(); idle();
      chk("repack_occ1", occ, 1);
      chk("repack_tail", r0, UOP_ST_U8);
      chk("repack_count1", rcnt, 2'd1);
      ren_ready = 1'b1; tick(); idle();

      // Full boundary
      for (int i = 0; i < 7; i++) begin
         dec_valid = 1'b1; dcnt = 2'd1; u0 = pool[i]; tick();
      end
      chk("full7_ready", dec_ready, 1'b0);
      u0 = UOP_BRANCH; u1 = UOP_BRANCH; dcnt = 2'd2; tick(); tick();
      idle();
      chk("full7_hold_occ", occ, 7);
      ren_ready = 1'b1; tick(); idle();
      chk("pop_occ5", occ, 5);
      chk("pop_ready", dec_ready, 1'b1);
      dec_valid = 1'b1; dcnt = 2'd1; u0 = UOP_LD_U8; tick();
      dcnt = 2'd2; u0 = UOP_INT_MUL; u1 = UOP_LINK; tick();
      idle();
      chk("full8_occ", occ, 8);
      chk("full8_ready", dec_ready, 1'b0);

      // Random stream with concurrent push/pop
      stream_on = 1'b1;
      for (int c = 0; c < 300; c++) begin
         dec_valid = ($urandom_range(0, 3) != 0);
         dcnt      = 2'($urandom_range(1, 2));
         u0        = pool[$urandom_range(0, 7)];
         u1        = pool[$urandom_range(0, 7)];
         ren_ready = 1'($urandom_range(0, 1));
         tick();
      end
      stream_on = 1'b0;
      idle();
      chk("wraps_ge_10", (stream_pushed / DEPTH) >= 10, 1'b1);

      // Flush priority and illegal count
      flush = 1'b1; tick(); idle();
      dec_valid = 1'b1; dcnt = 2'd2; u0 = UOP_INT_ALU; u1 = UOP_BRANCH; tick(); tick();
      idle();
      chk("pre_flush_occ", occ, 4);
      flush = 1'b1; dec_valid = 1'b1; dcnt = 2'd2; ren_ready = 1'b1; tick(); idle();
      chk("flush_occ", occ, 0);
      chk("flush_valid", ren_valid, 1'b0);
      dec_valid = 1'b1; dcnt = 2'd3; u0 = UOP_LINK; u1 = UOP_ST_U8; tick(); idle();
      chk("ill_flag", illegal, 1'b1);
      chk("ill_occ", occ, 2);
      chk("ill_uop0", r0, UOP_LINK);
      chk("ill_uop1", r1, UOP_ST_U8);
      flush = 1'b1; tick(); idle();
      chk("ill_after_flush", illegal, 1'b1);
      chk("occ_after_flush", occ, 0);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("ill_after_rst", illegal, 1'b0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
